sm_status_msg_tx: RTL and testbench
===================================

Name: sm_status_msg_tx

Overview:
- Serial transmitter at the far end of the path planner's status interface.
- Watches the bot's current node together with the planner's statusno/msg_type/field outputs.
- On arrival at a node that carries a status identifier, formats a fixed 10-byte ASCII SI message and shifts it out as 8N1 UART toward the XBee link.
- Runs on the 3.125 MHz system clock beside the planner.

Parameters:
- CLKS_PER_BIT, 27, clock cycles per UART bit (3.125 MHz / 27 ≈ 115.7 kbaud).
- SETTLE_CYCLES, 1, cycles to wait after a node change before sampling statusno/field/msg_type (covers the planner's one-cycle registered lag; legal range 1..7).
- NODE_NONE, 63, reset value of the previous-node register.

Ports:
- clk  input  1  3.125 MHz system clock.
- rst_n  input  1  asynchronous active-low reset.
- node  input  6  current node from line follower, 0..63.
- statusno  input  2  SI number from planner; 0 = no status at this node.
- msg_type  input  2  message type; only 1 (colour SI) is transmitted.
- field  input  2  terrain code: 0='M', 1='P', 2='R', 3='X'.
- tx  output  1  UART line, idle high.
- busy  output  1  high while a frame is being sent or one is pending.
- msg_done  output  1  one-cycle pulse after the stop bit of the last byte.
- overflow  output  1  sticky; set when an arrival is dropped.

Behaviour:
- Reset (async, rst_n low):
  - Outputs: tx=1, busy=0, msg_done=0, overflow=0.
  - Internal state: prev_node=NODE_NONE, FSM=IDLE, pending slot empty, settle counter cleared.
  - Reset mid-frame aborts the frame immediately; tx returns to 1 in the same cycle.
- Arrival detection:
  - Compare node against prev_node every cycle. On inequality, prev_node<=node and the settle counter loads SETTLE_CYCLES.
  - When the counter reaches 0, sample statusno, msg_type and field once.
  - The sample is a request only if statusno!=0 and msg_type==1; otherwise it is silently discarded.
  - A new node change during settling restarts the counter with the new node.
  - A node held constant produces exactly one request.
- Request buffering, one frame active plus one pending slot:
  - Request while IDLE: captured straight into the frame registers.
  - Request while sending and the slot is empty: stored in the slot.
  - Request while the slot is full: dropped, overflow<=1. overflow clears only on reset.
- Frame format, 10 bytes sent LSB-first, each as start(0), 8 data bits, stop(1):
  - 'S' 'I' '-' F D1 D0 '-' S '-' '#'
  - F is the field letter.
  - D1 and D0 are the decimal tens and ones of node (00..63), each as '0'+digit.
  - S = '0'+statusno.
  - Example: node=5, statusno=1, field=0 gives "SI-M05-1-#".
- Main FSM:
  - IDLE -> LOAD on a request or a full pending slot.
  - LOAD: select byte[idx], idx=0..9. Digits come from a registered divide-by-10 (compare/subtract; no `/` operator).
  - LOAD -> SEND: hand the byte to the UART sub-module with start=1 for one cycle.
  - SEND -> NEXT when the sub-module reports done.
  - NEXT -> LOAD if idx<9, with idx+1.
  - NEXT -> DONE if idx==9.
  - DONE: msg_done=1 for one cycle. Then go to LOAD if the pending slot is full (move it to the frame registers and clear the slot), else IDLE.
- Timing:
  - tx falls for the start bit 2 cycles after a request is captured in IDLE.
  - Each bit lasts exactly CLKS_PER_BIT cycles.
  - Gap between bytes ≤ 2 cycles. Whole frame ≈ 10×10×27 + 20 cycles.
- busy = (FSM!=IDLE) | pending_full; registered.

Decomposition:
- Package sm_msg_pkg:
  - FSM state enum (IDLE, LOAD, SEND, NEXT, DONE).
  - ASCII constants 'S', 'I', '-', '#', '0'.
  - Field-letter lookup and FRAME_LEN=10.
- Sub-module sm_uart_tx_byte:
  - Ports: clk, rst_n, start, data[7:0], tx, done.
  - Bit-rate counter plus 4-bit bit index; 8N1 framing.

Test Plan:
- field=0, msg_type=1; node 3→5 with statusno=1 a cycle later -> tx decodes "SI-M05-1-#"; every bit exactly 27 cycles; one msg_done pulse; busy low afterward.
- node 2→4 with statusno=0 -> tx stays 1, busy stays 0, no msg_done.
- node→7 with msg_type=2, statusno=2 -> no frame sent; then msg_type=1 with node→0, statusno=3 -> exactly one frame "SI-M00-3-#".
- Three arrivals during one frame (nodes 5, 7, 0 with nonzero statusno) -> frame for 5 completes, then frame for 7, two msg_done pulses total; arrival at 0 dropped, overflow=1.
- rst_n low at byte 4 of a frame -> tx=1 and busy=0 asynchronously; after release a new arrival at node 5 sends a complete correct frame.
- node held at 5 for 20000 cycles -> exactly one frame; NODE_NONE reset with node=0 at release and statusno=3 -> one "SI-M00-3-#" frame.

Source files
------------

// File: rtl/sm_status_msg_tx_pkg.sv
// Shared types, ASCII constants and helpers for the status-message transmitter.
package sm_msg_pkg;

   typedef enum logic [2:0] {IDLE, LOAD, SEND, NEXT, DONE} state_t;

   localparam int          FRAME_LEN  = 10;
   localparam logic [7:0]  ASCII_S    = 8'h53;
   localparam logic [7:0]  ASCII_I    = 8'h49;
   localparam logic [7:0]  ASCII_DASH = 8'h2D;
   localparam logic [7:0]  ASCII_HASH = 8'h23;
   localparam logic [7:0]  ASCII_ZERO = 8'h30;

   // One accepted arrival as sampled from the planner.
   typedef struct packed {
      logic [5:0] node;
      logic [1:0] statusno;
      logic [1:0] field;
   } req_t;

   // Frame being transmitted, with node already split into decimal digits.
   typedef struct packed {
      logic [3:0] tens;
      logic [3:0] ones;
      logic [1:0] statusno;
      logic [1:0] field;
   } frame_t;

   function automatic logic [7:0] field_letter(input logic [1:0] f);
      case (f)
         2'd0:    return 8'h4D;  // 'M'
         2'd1:    return 8'h50;  // 'P'
         2'd2:    return 8'h52;  // 'R'
         default: return 8'h58;  // 'X'
      endcase
   endfunction

   // Divide-by-10 by repeated compare/subtract; node <= 63 needs at most 6 steps.
   function automatic frame_t to_frame(input req_t r);
      frame_t     f;
      logic [5:0] rem;
      logic [3:0] tens;
      rem  = r.node;
      tens = 4'd0;
      for (int i = 0; i < 6; i++) begin
         if (rem >= 6'd10) begin
            rem  = rem - 6'd10;
            tens = tens + 4'd1;
         end
      end
      f.tens     = tens;
      f.ones     = rem[3:0];
      f.statusno = r.statusno;
      f.field    = r.field;
      return f;
   endfunction

endpackage

// File: rtl/sm_status_msg_tx_if.sv
// Planner status bus: current node plus the planner's per-node status outputs.
interface sm_status_msg_tx_if;
   logic [5:0] node;
   logic [1:0] statusno;
   logic [1:0] msg_type;
   logic [1:0] field;

   modport master (output node, statusno, msg_type, field);
   modport slave  (input  node, statusno, msg_type, field);
endinterface

// File: rtl/sm_uart_tx_byte.sv
// 8N1 byte serializer: start bit, 8 data bits LSB-first, stop bit.
module sm_uart_tx_byte #(
   parameter int CLKS_PER_BIT = 27
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] data,
   output logic       tx,
   output logic       done
);
   localparam int CW = $clog2(CLKS_PER_BIT);

   logic [CW-1:0] cnt;
   logic [3:0]    bit_idx;
   logic [9:0]    shreg;
   logic          active;
   logic          last_cnt;

   assign last_cnt = (cnt == CW'(CLKS_PER_BIT - 1));
   // done is asserted during the final cycle of the stop bit so the next byte can follow quickly.
   assign done     = active && last_cnt && (bit_idx == 4'd9);

   // Bit timer and bit sequencer; tx is registered so every bit is exactly CLKS_PER_BIT long.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
      if (!rst_n) begin
         tx      <= 1'b1;
         active  <= 1'b0;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '1;
      end else if (!active) begin
         if (start) begin
            shreg   <= {1'b1, data, 1'b0};
            tx      <= 1'b0;
            active  <= 1'b1;
            cnt     <= '0;
            bit_idx <= '0;
         end
      end else if (last_cnt) begin
         cnt <= '0;
         if (bit_idx == 4'd9) begin
            active <= 1'b0;
         end else begin
            bit_idx <= bit_idx + 4'd1;
            tx      <= shreg[bit_idx + 4'd1];
         end
      end else begin
         cnt <= cnt + 1'b1;
      end
   end
endmodule

// File: rtl/sm_status_msg_tx.sv
// Status-message transmitter: detects node arrivals and sends "SI-Fdd-s-#" frames over UART.
module sm_status_msg_tx
   import sm_msg_pkg::*;
#(
   parameter int         CLKS_PER_BIT  = 27,
   parameter int         SETTLE_CYCLES = 1,
   parameter logic [5:0] NODE_NONE     = 6'd63
) (
   input  logic                clk,
   input  logic                rst_n,
   sm_status_msg_tx_if.slave   plan,
   output logic                tx,
   output logic                busy,
   output logic                msg_done,
   output logic                overflow
);
   localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

   state_t     state, state_next;
   logic [5:0] prev_node;
   logic [2:0] settle_cnt;
   logic       settle_act;
   logic       req_valid;
   req_t       req, pend;
   frame_t     frame;
   logic       pend_full, pend_full_d, pend_take, ovf_set, store_req;
   logic [3:0] idx;
   logic [7:0] tx_byte;
   logic       uart_start, uart_done;

   // Arrival detection: restart the settle timer on every node change, sample once it expires.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_node  <= NODE_NONE;
         settle_cnt <= '0;
         settle_act <= 1'b0;
      end else if (plan.node != prev_node) begin
         prev_node  <= plan.node;
         settle_cnt <= 3'(SETTLE_CYCLES);
         settle_act <= 1'b1;
      end else if (settle_act) begin
         if (settle_cnt == 3'd0) settle_act <= 1'b0;
         else                    settle_cnt <= settle_cnt - 3'd1;
      end
   end

   // Request qualification and pending-slot bookkeeping.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      req          = '0;
      req.node     = prev_node;
      req.statusno = plan.statusno;
      req.field    = plan.field;
      req_valid    = settle_act && (settle_cnt == 3'd0) && (plan.node == prev_node) &&
                     (plan.statusno != 2'd0) && (plan.msg_type == 2'd1);
      pend_take    = pend_full && ((state == DONE) || ((state == IDLE) && !req_valid));
      store_req    = req_valid && (state != IDLE) && (!pend_full || pend_take);
      ovf_set      = req_valid && (state != IDLE) && pend_full && !pend_take;
      pend_full_d  = pend_full;
      if (pend_take) pend_full_d = 1'b0;
      if (store_req) pend_full_d = 1'b1;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // FSM next-state and UART handshake.
   always_comb begin
      state_next = state;
      uart_start = 1'b0;
      case (state)
         IDLE: if (req_valid || pend_full) state_next = LOAD;
         LOAD: begin
            uart_start = 1'b1;
            state_next = SEND;
         end
         SEND: if (uart_done) state_next = NEXT;
         NEXT: state_next = (idx == LAST_IDX) ? DONE : LOAD;
         DONE: state_next = pend_full ? LOAD : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Control registers: byte index, pending flag, sticky overflow, registered status outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_full <= 1'b0;
         idx       <= '0;
         overflow  <= 1'b0;
         busy      <= 1'b0;
         msg_done  <= 1'b0;
      end else begin
         pend_full <= pend_full_d;
         if (ovf_set) overflow <= 1'b1;
         if ((state == NEXT) && (idx != LAST_IDX))  idx <= idx + 4'd1;
         else if ((state == IDLE) || (state == DONE)) idx <= '0;
         busy     <= (state_next != IDLE) || pend_full_d;
         msg_done <= (state_next == DONE);
      end
   end

   // Frame and pending payloads.
   always_ff @(posedge clk) begin
      // NOTE: payload registers carry no reset; they are only ever read while their valid flag/state says so.
      if ((state == IDLE) && req_valid) frame <= to_frame(req);
      else if (pend_take)               frame <= to_frame(pend);
      if (store_req) pend <= req;
   end

   // Byte selection for the current frame position.
   always_comb begin
      tx_byte = ASCII_HASH;
      case (idx)
         4'd0: tx_byte = ASCII_S;
         4'd1: tx_byte = ASCII_I;
         4'd2: tx_byte = ASCII_DASH;
         4'd3: tx_byte = field_letter(frame.field);
         4'd4: tx_byte = ASCII_ZERO + {4'd0, frame.tens};
         4'd5: tx_byte = ASCII_ZERO + {4'd0, frame.ones};
         4'd6: tx_byte = ASCII_DASH;
         4'd7: tx_byte = ASCII_ZERO + {6'd0, frame.statusno};
         4'd8: tx_byte = ASCII_DASH;
         default: tx_byte = ASCII_HASH;
      endcase
   end

   sm_uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
      .clk   (clk),
      .rst_n (rst_n),
      .start (uart_start),
      .data  (tx_byte),
      .tx    (tx),
      .done  (uart_done)
   );
endmodule

// File: tb/tb_sm_status_msg_tx.sv
// Self-checking bench for sm_status_msg_tx: UART decoder plus string-level frame model.
module tb_sm_status_msg_tx;
   localparam int CPB = 27;

   logic clk, rst_n;
   logic tx, busy, msg_done, overflow;
   sm_status_msg_tx_if plan_if ();

   sm_status_msg_tx dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .plan     (plan_if.slave),
      .tx       (tx),
      .busy     (busy),
      .msg_done (msg_done),
      .overflow (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   // UART receiver: requires each bit to hold its value for all CPB cycles.
   logic [7:0] rx_q[$];
   logic [9:0] rx_bits;
   int         rx_cnt, rx_b;
   bit         rx_act = 1'b0;
   bit         rx_bad;
   int         width_err = 0;
   int         done_cnt  = 0;

   always @(negedge clk) begin
      if (rst_n !== 1'b1) begin
         rx_act = 1'b0;
      end else begin
         if (!rx_act && tx === 1'b0) begin
            rx_act  = 1'b1;
            rx_cnt  = 0;
            rx_bad  = 1'b0;
            rx_bits = '0;
         end
         if (rx_act) begin
            rx_b = rx_cnt / CPB;
            if (rx_cnt % CPB == 0)       rx_bits[rx_b] = tx;
            else if (tx !== rx_bits[rx_b]) rx_bad = 1'b1;
            rx_cnt++;
            if (rx_cnt == 10 * CPB) begin
               rx_act = 1'b0;
               if (rx_bits[0] !== 1'b0 || rx_bits[9] !== 1'b1) rx_bad = 1'b1;
               rx_q.push_back(rx_bits[8:1]);
               if (rx_bad) width_err++;
            end
         end
         if (msg_done === 1'b1) done_cnt++;
      end
   end

   task automatic check_val(string tag, logic [31:0] obs, logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_str(string tag, string obs, string exp);
      n_assert++;
      assert (obs == exp) else begin
         n_fail++;
         $error("FAIL %s: observed \"%s\" expected \"%s\"", tag, obs, exp);
      end
   endtask

   // Reference model: the frame text follows directly from the message rules.
   function automatic string frame_str(int n, int st, int fd);
      string l;
      case (fd)
         0: l = "M";
         1: l = "P";
         2: l = "R";
         default: l = "X";
      endcase
      return $sformatf("SI-%s%02d-%0d-#", l, n, st);
   endfunction

   task automatic arrival(int n, int st, int mt, int fd);
      @(posedge clk); #1;
      plan_if.node = 6'(n);
      @(posedge clk); #1;
      plan_if.statusno = 2'(st);
      plan_if.msg_type = 2'(mt);
      plan_if.field    = 2'(fd);
   endtask

   task automatic wait_idle(string tag, int budget);
      int c;
      c = 0;
      repeat (8) @(negedge clk);
      while ((busy === 1'b1 || rx_act) && c < budget) begin
         @(negedge clk);
         c++;
      end
      check_val({tag, " idle timeout"}, 32'(c < budget), 32'd1);
      repeat (4) @(negedge clk);
   endtask

   task automatic check_rx(string tag, string exp);
      string got;
      got = "";
      while (rx_q.size() > 0) got = $sformatf("%s%c", got, rx_q.pop_front());
      check_str(tag, got, exp);
   endtask

   int    exp_done = 0;
   int    cur_node;
   int    c;
   bit    seen_busy, seen_low;
   string exp_s;

   initial begin
      rst_n = 1'b0;
      plan_if.node = 6'd3; plan_if.statusno = 2'd0; plan_if.msg_type = 2'd1; plan_if.field = 2'd0;
      repeat (3) @(negedge clk);
      check_val("reset tx", tx, 1);
      check_val("reset busy", busy, 0);
      check_val("reset msg_done", msg_done, 0);
      check_val("reset overflow", overflow, 0);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (20) @(negedge clk);

      // Basic frame with one-cycle planner lag on statusno.
      arrival(5, 1, 1, 0);
      wait_idle("t1", 5000);
      exp_done++;
      check_rx("t1 frame", "SI-M05-1-#");
      check_val("t1 bit timing errors", width_err, 0);
      check_val("t1 msg_done pulses", done_cnt, exp_done);
      check_val("t1 busy after", busy, 0);

      // statusno = 0 produces nothing.
      arrival(2, 0, 1, 0);
      repeat (5) @(posedge clk);
      arrival(4, 0, 1, 0);
      seen_busy = 0; seen_low = 0;
      repeat (300) begin
         @(negedge clk);
         seen_busy |= (busy === 1'b1);
         seen_low  |= (tx !== 1'b1);
      end
      check_val("t2 busy seen", seen_busy, 0);
      check_val("t2 tx low seen", seen_low, 0);
      check_val("t2 msg_done pulses", done_cnt, exp_done);

      // msg_type filter, then an accepted arrival at node 0.
      arrival(7, 2, 2, 0);
      repeat (300) @(negedge clk);
      check_rx("t3 filtered", "");
      arrival(0, 3, 1, 0);
      wait_idle("t3", 5000);
      exp_done++;
      check_rx("t3 frame", "SI-M00-3-#");
      check_val("t3 msg_done pulses", done_cnt, exp_done);

      // Three arrivals inside one frame: one active, one pending, one dropped.
      arrival(5, 1, 1, 1);
      repeat (200) @(posedge clk);
      arrival(7, 2, 1, 2);
      repeat (200) @(posedge clk);
      arrival(0, 3, 1, 3);
      wait_idle("t4", 12000);
      exp_done += 2;
      check_rx("t4 frames", {"SI-P05-1-#", "SI-R07-2-#"});
      check_val("t4 msg_done pulses", done_cnt, exp_done);
      check_val("t4 overflow", overflow, 1);
      check_val("t4 bit timing errors", width_err, 0);

      // Reset during byte 4 of a frame.
      arrival(9, 2, 1, 0);
      c = 0;
      while (rx_q.size() < 4 && c < 5000) begin
         @(negedge clk);
         c++;
      end
      check_val("t5 reach byte 4", 32'(c < 5000), 1);
      repeat (40) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_val("t5 async tx", tx, 1);
      check_val("t5 async busy", busy, 0);
      check_val("t5 overflow cleared", overflow, 0);
      plan_if.node = 6'd5; plan_if.statusno = 2'd2; plan_if.msg_type = 2'd1; plan_if.field = 2'd1;
      repeat (5) @(posedge clk);
      rx_q.delete();
      #2 rst_n = 1'b1;
      wait_idle("t5", 5000);
      exp_done++;
      check_rx("t5 frame after reset", "SI-P05-2-#");
      check_val("t5 msg_done pulses", done_cnt, exp_done);

      // Node held constant: no repeat frames.
      repeat (20000) @(negedge clk);
      check_rx("t6 held node", "");
      check_val("t6 msg_done pulses", done_cnt, exp_done);

      // Arrival at node 0 straight out of reset.
      @(posedge clk); #2 rst_n = 1'b0;
      plan_if.node = 6'd0; plan_if.statusno = 2'd3; plan_if.msg_type = 2'd1; plan_if.field = 2'd0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      wait_idle("t7", 5000);
      exp_done++;
      check_rx("t7 frame", "SI-M00-3-#");
      check_val("t7 msg_done pulses", done_cnt, exp_done);
      cur_node = 0;

      // Random single arrivals against the model.
      for (int i = 0; i < 5; i++) begin
         int n, st, mt, fd;
         n  = int'($urandom_range(63, 0));
         if (n == cur_node) n = (n + 1) % 64;
         st = int'($urandom_range(3, 0));
         mt = (i % 2 == 0) ? 1 : int'($urandom_range(3, 0));
         fd = int'($urandom_range(3, 0));
         cur_node = n;
         arrival(n, st, mt, fd);
         if (st != 0 && mt == 1) begin
            exp_s = frame_str(n, st, fd);
            exp_done++;
         end else begin
            exp_s = "";
         end
         wait_idle($sformatf("rand%0d", i), 5000);
         check_rx($sformatf("rand%0d n=%0d st=%0d mt=%0d fd=%0d", i, n, st, mt, fd), exp_s);
         check_val($sformatf("rand%0d msg_done pulses", i), done_cnt, exp_done);
      end
      check_val("final bit timing errors", width_err, 0);
      check_val("final busy", busy, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
